// File: rtl/otter_intr_pkg.sv
// otter_intr_pkg: shared types and helpers for the OTTER interrupt controller.
//   intr_state_t   - controller state (IDLE / REQ / SERVICE)
//   intr_sel_t     - result of the fixed-priority selector
//   intr_prio_sel  - lowest set bit of a 32-bit vector, with valid flag
package otter_intr_pkg;

   localparam int INTR_N_SRC_DEFAULT = 8;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      REQ     = 2'd1,
      SERVICE = 2'd2
   } intr_state_t;

   typedef struct packed {
      logic       valid;
      logic [4:0] idx;
   } intr_sel_t;

   // Scan from the top so the last hit (lowest index) wins.
   function automatic intr_sel_t intr_prio_sel(input logic [31:0] v);
      intr_sel_t s;
      s.valid = 1'b0;
      s.idx   = 5'd0;
      for (int i = 31; i >= 0; i--) begin
         if (v[i]) begin
            s.valid = 1'b1;
            s.idx   = 5'(i);
         end
      end
      return s;
   endfunction

endpackage

// File: rtl/otter_sync_edge.sv
// otter_sync_edge: one-bit multi-flop synchronizer followed by a rising-edge
// detector.
//   clk_i   - clock
//   rst_ni  - async active-low reset
//   d_i     - asynchronous level input
//   rise_o  - one-cycle pulse when the synchronized level goes 0 -> 1
module otter_sync_edge
   import otter_intr_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic d_i,
   output logic rise_o
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   prev_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync_q <= '0;
         prev_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
         prev_q <= sync_q[SYNC_STAGES-1];
      end
   end

   // Combinational so pending lands on edge SYNC_STAGES.
   assign rise_o = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/otter_intr_ctrl.sv
// otter_intr_ctrl: interrupt controller for the OTTER control unit.
//   CLK, RST_N   - clock, async active-low reset
//   irq_in       - asynchronous peripheral interrupt lines (rising edge = request)
//   mie          - global interrupt enable (mstatus.MIE)
//   mask_we/wdata- enable-mask write port
//   int_taken    - CPU entered its interrupt state
//   mret_exec    - CPU executed MRET
//   INTR         - registered request to the CPU
//   irq_id       - selected source in REQ, latched source otherwise
//   pending      - raw pending bits
//   mask         - current enable mask
//   in_service   - taken interrupt not yet retired
module otter_intr_ctrl
   import otter_intr_pkg::*;
#(
   parameter int N_SRC       = INTR_N_SRC_DEFAULT,
   parameter int SYNC_STAGES = 2
) (
   input  logic                                       CLK,
   input  logic                                       RST_N,
   input  logic [N_SRC-1:0]                           irq_in,
   input  logic                                       mie,
   input  logic                                       mask_we,
   input  logic [N_SRC-1:0]                           mask_wdata,
   input  logic                                       int_taken,
   input  logic                                       mret_exec,
   output logic                                       INTR,
   output logic [((N_SRC > 1) ? $clog2(N_SRC) : 1)-1:0] irq_id,
   output logic [N_SRC-1:0]                           pending,
   output logic [N_SRC-1:0]                           mask,
   output logic                                       in_service
);

   localparam int IDW = (N_SRC > 1) ? $clog2(N_SRC) : 1;

   intr_state_t      state_q;
   logic             intr_q;
   logic             in_service_q;
   logic [IDW-1:0]   id_q;
   logic [N_SRC-1:0] pending_q, pending_d;
   logic [N_SRC-1:0] mask_q;
   logic [N_SRC-1:0] rise;
   logic [N_SRC-1:0] clr;
   logic [N_SRC-1:0] elig;
   intr_sel_t        sel;
   logic [IDW-1:0]   sel_idx;
   logic             take;
   logic             sel_unused;

   for (genvar g = 0; g < N_SRC; g++) begin : g_src
      otter_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
         .clk_i  (CLK),
         .rst_ni (RST_N),
         .d_i    (irq_in[g]),
         .rise_o (rise[g])
      );
   end

   assign elig       = pending_q & mask_q;
   assign sel        = intr_prio_sel(32'(elig));
   assign sel_idx    = sel.idx[IDW-1:0];
   assign sel_unused = ^sel.idx;
   assign take       = (state_q == REQ) && int_taken;

   // A new edge in the same cycle as the clear keeps the bit set.
   always_comb begin
      clr = '0;
      if (take && sel.valid) clr[sel_idx] = 1'b1;
      pending_d = (pending_q & ~clr) | rise;
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         pending_q <= '0;
         mask_q    <= '0;
      end else begin
         pending_q <= pending_d;
         if (mask_we) mask_q <= mask_wdata;
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q      <= IDLE;
         intr_q       <= 1'b0;
         in_service_q <= 1'b0;
         id_q         <= '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (mie && sel.valid) begin
                  state_q <= REQ;
                  intr_q  <= 1'b1;
               end
            end
            REQ: begin
               // int_taken has priority over withdrawal.
               if (int_taken) begin
                  state_q      <= SERVICE;
                  intr_q       <= 1'b0;
                  in_service_q <= 1'b1;
                  id_q         <= sel_idx;
               end else if (!mie || !sel.valid) begin
                  state_q <= IDLE;
                  intr_q  <= 1'b0;
               end
            end
            SERVICE: begin
               // Returning through IDLE guarantees one idle cycle after MRET.
               if (mret_exec) begin
                  state_q      <= IDLE;
                  in_service_q <= 1'b0;
               end
            end
            default: begin
               state_q <= IDLE;
               intr_q  <= 1'b0;
            end
         endcase
      end
   end

   assign INTR       = intr_q;
   assign irq_id     = (state_q == REQ) ? sel_idx : id_q;
   assign pending    = pending_q;
   assign mask       = mask_q;
   assign in_service = in_service_q;

endmodule
